// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, frame defaults and sizing helper.
package uart_pkg;

    localparam logic [1:0] S0_Idle  = 2'd0;
    localparam logic [1:0] S1_Start = 2'd1;
    localparam logic [1:0] S2_Data  = 2'd2;
    localparam logic [1:0] S3_Stop  = 2'd3;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for an asynchronous input, reset to RST_VAL.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) {o_q, meta} <= {RST_VAL, RST_VAL};
        else {o_q, meta} <= {meta, i_d};
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with oversampled start validation, centre sampling
// and stop-bit error reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_signal,
    input  logic                 i_srx,
    output logic                 o_Rx_valid,
    output logic [DATA_BITS-1:0] o_Rx_data,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int CW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_BITS);

    logic [1:0]           state, state_nx;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] sh;
    logic [DATA_BITS:0]   sh_nx;
    logic                 at_mid, at_end, last_bit;
    logic                 cnt_clr, bit_clr, shift, stop_smp;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_srx),
        .o_q    (rx_s)
    );

    assign at_mid   = cnt == CW'(OVERSAMPLE / 2 - 1);
    assign at_end   = cnt == CW'(OVERSAMPLE - 1);
    assign last_bit = bit_cnt == BW'(DATA_BITS - 1);
    assign sh_nx    = {rx_s, sh};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S0_Idle;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (i_signal)
            case (state)
                S0_Idle:  state_nx = rx_s ? S0_Idle : S1_Start;
                S1_Start: if (at_mid) state_nx = rx_s ? S0_Idle : S2_Data;
                S2_Data:  if (at_end && last_bit) state_nx = S3_Stop;
                S3_Stop:  if (at_end) state_nx = S0_Idle;
                default:  state_nx = S0_Idle;
            endcase
    end

    // Tick-qualified strobes that steer the counters and the shifter.
    always_comb begin
        o_busy   = state != S0_Idle;
        bit_clr  = i_signal && state == S1_Start && at_mid;
        shift    = i_signal && state == S2_Data && at_end;
        stop_smp = i_signal && state == S3_Stop && at_end;
        cnt_clr  = state == S0_Idle || bit_clr || at_end;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt         <= '0;
            bit_cnt     <= '0;
            sh          <= '0;
            o_Rx_data   <= '0;
            o_Rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_Rx_valid  <= stop_smp && rx_s;
            o_frame_err <= stop_smp && !rx_s;
            if (i_signal) cnt <= cnt_clr ? '0 : cnt + 1'b1;
            if (bit_clr) bit_cnt <= '0;
            else if (shift && !last_bit) bit_cnt <= bit_cnt + 1'b1;
            if (shift) sh <= sh_nx[DATA_BITS:1];
            if (stop_smp && rx_s) o_Rx_data <= sh;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame sequence against uart_rx at OVERSAMPLE=16, tick every 4 clocks.
module tb_uart_rx;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_signal = 1'b0;
    logic       i_srx = 1'b1;
    logic       o_Rx_valid, o_frame_err, o_busy;
    logic [7:0] o_Rx_data;

    int n_cmp = 0, n_fail = 0;
    int n_valid = 0, n_err = 0, n_both = 0, n_long = 0, n_chg = 0;
    logic [7:0] log_q[$];
    logic       prev_valid = 1'b0, prev_err = 1'b0;
    logic [7:0] prev_data;
    logic       saw_busy;
    int         tdiv = 0;

    localparam int BIT = 64;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_signal   (i_signal),
        .i_srx      (i_srx),
        .o_Rx_valid (o_Rx_valid),
        .o_Rx_data  (o_Rx_data),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        tdiv <= (tdiv == 3) ? 0 : tdiv + 1;
        i_signal <= (tdiv == 3);
    end

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_Rx_valid) begin
                log_q.push_back(o_Rx_data);
                n_valid++;
            end
            if (o_frame_err) n_err++;
            if (o_Rx_valid && o_frame_err) n_both++;
            if ((o_Rx_valid && prev_valid) || (o_frame_err && prev_err)) n_long++;
            if (o_Rx_data !== prev_data && !o_Rx_valid) n_chg++;
        end
        prev_valid = o_Rx_valid;
        prev_err   = o_frame_err;
        prev_data  = o_Rx_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A short low stop bit still reads low at its centre but frees the line early.
    task automatic send(input logic [7:0] b, input logic stop, input int bc);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            i_srx = f[i];
            if (i == 9 && !stop) begin
                repeat (bc * 3 / 4) @(posedge i_clk);
                i_srx = 1'b1;
                repeat (bc - bc * 3 / 4) @(posedge i_clk);
            end else
                repeat (bc) @(posedge i_clk);
        end
        i_srx = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        chk("rst_valid", o_Rx_valid, 0);
        chk("rst_err", o_frame_err, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_data", o_Rx_data, 0);
        i_rst_n = 1'b1;
        repeat (40) @(posedge i_clk);

        send(8'hA5, 1'b1, BIT);
        repeat (BIT) @(posedge i_clk);
        @(negedge i_clk);
        chk("a5_nvalid", n_valid, 1);
        chk("a5_log", log_q[0], 8'hA5);
        chk("a5_data", o_Rx_data, 8'hA5);
        chk("a5_nerr", n_err, 0);

        saw_busy = 1'b0;
        i_srx = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge i_clk);
            saw_busy |= o_busy;
        end
        i_srx = 1'b1;
        repeat (2 * BIT) @(negedge i_clk);
        chk("glitch_busy_seen", saw_busy, 1);
        chk("glitch_idle", o_busy, 0);
        chk("glitch_nvalid", n_valid, 1);
        chk("glitch_nerr", n_err, 0);

        send(8'h11, 1'b1, BIT);
        repeat (BIT) @(posedge i_clk);
        send(8'h3C, 1'b0, BIT);
        repeat (2 * BIT) @(posedge i_clk);
        @(negedge i_clk);
        chk("ferr_nvalid", n_valid, 2);
        chk("ferr_log", log_q[1], 8'h11);
        chk("ferr_nerr", n_err, 1);
        chk("ferr_data_kept", o_Rx_data, 8'h11);

        send(8'h55, 1'b1, BIT);
        send(8'hAA, 1'b1, BIT);
        repeat (BIT) @(posedge i_clk);
        @(negedge i_clk);
        chk("b2b_nvalid", n_valid, 4);
        chk("b2b_first", log_q[2], 8'h55);
        chk("b2b_second", log_q[3], 8'hAA);
        chk("b2b_nerr", n_err, 1);

        i_srx = 1'b0;
        repeat (5 * BIT) @(posedge i_clk);
        i_srx = 1'b1;
        repeat (BIT / 2) @(posedge i_clk);
        @(negedge i_clk);
        chk("mid_busy", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_Rx_valid, 0);
        chk("mid_rst_err", o_frame_err, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_data", o_Rx_data, 0);
        repeat (10) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (5 * BIT) @(posedge i_clk);
        send(8'h0F, 1'b1, BIT);
        repeat (BIT) @(posedge i_clk);
        @(negedge i_clk);
        chk("post_rst_nvalid", n_valid, 5);
        chk("post_rst_log", log_q[4], 8'h0F);
        chk("post_rst_data", o_Rx_data, 8'h0F);
        chk("post_rst_nerr", n_err, 1);

        send(8'h00, 1'b1, 66);
        repeat (2 * BIT) @(posedge i_clk);
        send(8'hFF, 1'b1, 62);
        repeat (2 * BIT) @(posedge i_clk);
        send(8'h80, 1'b1, 66);
        repeat (2 * BIT) @(posedge i_clk);
        send(8'h01, 1'b1, 62);
        repeat (2 * BIT) @(posedge i_clk);
        @(negedge i_clk);
        chk("skew_nvalid", n_valid, 9);
        chk("skew_00", log_q[5], 8'h00);
        chk("skew_ff", log_q[6], 8'hFF);
        chk("skew_80", log_q[7], 8'h80);
        chk("skew_01", log_q[8], 8'h01);
        chk("skew_nerr", n_err, 1);
        chk("end_busy", o_busy, 0);

        chk("never_both", n_both, 0);
        chk("pulse_width", n_long, 0);
        chk("data_only_on_valid", n_chg, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receive-side counterpart of the team's UART transmitter. It recovers 8N1 frames from the asynchronous serial line using an oversampling tick supplied by the shared baud generator. Each good byte is presented with a one-cycle valid pulse, and stop-bit errors are flagged. It sits between the board RX pin and the same byte-level user logic that drives the transmitter.

## Interface
Parameters:
- OVERSAMPLE, 16, `i_signal` ticks per bit period; even, 4..32.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_signal  in  1  oversample tick, one-cycle pulse, OVERSAMPLE pulses per bit.
- i_srx  in  1  raw serial line; idles high; asynchronous to i_clk.
- o_Rx_valid  out  1  one-cycle pulse; o_Rx_data holds a new good byte.
- o_Rx_data  out  DATA_BITS  last good byte; holds its value until the next good frame.
- o_frame_err  out  1  one-cycle pulse; stop bit sampled low, byte discarded.
- o_busy  out  1  high while a frame is in progress (any state other than S0_Idle).

## Operation
- i_srx passes through a 2-FF synchronizer, reset to 1. All decisions use the synchronized value `rx_s`.
- Tick counter `cnt` runs 0..OVERSAMPLE-1 and advances only on i_signal.
- Bit counter `bit_cnt` runs 0..DATA_BITS-1.
- Shift register `sh` is DATA_BITS wide and shifts right. Each sampled bit enters at the MSB, so after DATA_BITS samples the first bit sits at the LSB.
- State machine (advances only on an i_signal cycle unless noted):
  - S0_Idle: when rx_s==0 -> S1_Start, cnt=0.
  - S1_Start: when cnt==OVERSAMPLE/2-1 (start-bit centre):
    - rx_s==0 -> S2_Data, cnt=0, bit_cnt=0.
    - rx_s==1 -> S0_Idle (glitch rejected; no pulse).
  - S2_Data: when cnt==OVERSAMPLE-1: sample rx_s into sh, cnt=0.
    - If bit_cnt==DATA_BITS-1 -> S3_Stop; otherwise bit_cnt+1.
  - S3_Stop: when cnt==OVERSAMPLE-1: sample rx_s.
    - 1 -> o_Rx_data<=sh, o_Rx_valid pulse.
    - 0 -> o_frame_err pulse; o_Rx_data unchanged.
    - Either way -> S0_Idle.
  - Unused state encodings -> S0_Idle.
- Returning to idle at the stop-bit centre lets a start edge arriving half a bit later be caught, so back-to-back frames are received without loss.
- A stop bit sampled low returns to S0_Idle. If the line is still low, the next tick re-enters S1_Start, and that start is validated normally (break condition produces repeated frame errors, no valid).
- No receive buffer. The user must consume o_Rx_data before the next o_Rx_valid; there is no overrun flag.

## Timing
- Reset values: o_Rx_valid=0, o_frame_err=0, o_busy=0, o_Rx_data=0, state=S0_Idle, cnt=0, bit_cnt=0, sh=0.
- Input latency: 2 i_clk cycles through the synchronizer.
- Each data bit is sampled on tick OVERSAMPLE/2 + k*OVERSAMPLE after the detected start edge, for k=1..DATA_BITS.
- o_Rx_valid / o_frame_err:
  - Assert one i_clk after the stop-centre tick.
  - Stay high for exactly one cycle.
  - Are never both high in the same cycle.
- o_Rx_data changes only in the same cycle that o_Rx_valid is high.
- Ticks arrive at most every cycle. With i_signal held high, one tick equals one clock.
- Reset asserted mid-frame: all outputs clear immediately. After release, reception restarts at the next falling edge; a partial frame is never reported.
- Tolerance: ±3% baud mismatch at OVERSAMPLE=16.

## Structure
- Package uart_pkg:
  - State localparams S0_Idle..S3_Stop, 2-bit encoding.
  - DATA_BITS default.
  - OVERSAMPLE default, shared with the baud generator.
- Sub-module uart_sync: 2-FF synchronizer with parameterized reset value, reusable for other async inputs.
- Receiver FSM, counters and shift register stay in uart_rx.

## Test plan
- Frame 0xA5 at OVERSAMPLE=16, i_signal every 4 clocks -> one o_Rx_valid, o_Rx_data=0xA5, o_frame_err stays 0.
- Line low for 4 ticks then high -> o_busy pulses; no o_Rx_valid, no o_frame_err; back in S0_Idle.
- Good frame 0x11, then frame 0x3C with stop bit low -> o_frame_err pulse, o_Rx_data stays 0x11.
- Back-to-back 0x55, 0xAA with zero idle between frames -> two o_Rx_valid pulses, data 0x55 then 0xAA.
- i_rst_n low during bit 4 of 0xF0, then a fresh frame 0x0F -> outputs 0 immediately; only 0x0F is reported.
- Loopback from the team's transmitter, bytes 0x00, 0xFF, 0x80, 0x01; baud skewed ±3% -> all four bytes received correctly, no errors.
